paralelo_serial_tx: RTL and testbench

Transmit end of the serial PHY lane, and the counterpart to serial_paralelo.
- Accepts bytes on a valid/ready handshake and holds one byte in a buffer.
- Serialises each byte MSB-first, one bit per clk_32f cycle.
- Sends COM/IDLE symbol 0xBC when it has no data, so the receiver can achieve and keep comma lock.
- Byte framing comes from an internal 3-bit bit counter, replacing the external clk_4f, so the block uses a single clock.

---
 rtl/serial_phy_pkg.sv | 18 +
 rtl/paralelo_serial_tx.sv | 108 ++++++++++
 tb/tb_paralelo_serial_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_phy_pkg.sv
// Shared definitions for the serial PHY lane (transmitter and receiver).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package serial_phy_pkg;

  // Comma symbol, also used as idle fill between data bytes
  localparam logic [7:0] COM_SYM  = 8'hBC;
  localparam logic [7:0] IDLE_SYM = COM_SYM;

  // Commas sent after reset before the lane accepts data
  localparam int unsigned SYNC_COUNT_DEF = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } phy_state_e;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: MSB-first, 8 clk_32f cycles per symbol, comma sync then idle fill.
// Latency: accepted byte reaches data_out 1..8 cycles later, after the next symbol boundary.
// Backpressure: one-byte holding buffer; ready_out low during sync or while the buffer is full.
module paralelo_serial_tx #(
  parameter int unsigned SYNC_COUNT = serial_phy_pkg::SYNC_COUNT_DEF,
  parameter logic [7:0]  IDLE_SYM   = serial_phy_pkg::IDLE_SYM
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       byte_start,
  output logic       tx_active
);
  import serial_phy_pkg::*;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  phy_state_e state;
  phy_state_e state_nxt;
  logic [3:0] sync_cnt;
  logic [3:0] sync_cnt_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] sym;
  logic       hold_valid;
  logic [7:0] hold_data;
  logic       load;
  logic       pop;
  logic       accept;

  // A new symbol is chosen whenever the bit counter wraps to zero
  assign load      = (bit_cnt == 3'd0);
  assign ready_out = (state == ACTIVE) && !hold_valid;
  assign accept    = valid_in && ready_out;
  assign tx_active = (state == ACTIVE);

  // State register: sync phase progress and mode
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state    <= SYNC;
      sync_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      sync_cnt <= sync_cnt_nxt;
    end
  end

  // Next-state and symbol selection; only load edges can change mode
  always_comb begin
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    sym          = IDLE_SYM;
    pop          = 1'b0;
    if (load) begin
      case (state)
        SYNC: begin
          sync_cnt_nxt = sync_cnt + 4'd1;
          if (sync_cnt == SYNC_LAST) begin
            state_nxt = ACTIVE;
          end
        end
        ACTIVE: begin
          if (hold_valid) begin
            sym = hold_data;
            pop = 1'b1;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  // Serialiser: load a full symbol, then walk down from bit 6 to bit 0
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      data_out   <= 1'b0;
      byte_start <= 1'b0;
    end else if (load) begin
      shift      <= sym;
      data_out   <= sym[7];
      byte_start <= 1'b1;
      bit_cnt    <= 3'd1;
    end else begin
      data_out   <= shift[3'd7 - bit_cnt];
      byte_start <= 1'b0;
      bit_cnt    <= bit_cnt + 3'd1;
    end
  end

  // Holding buffer: accept and pop never coincide since accept needs it empty
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'd0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= data_in;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed + randomized bench for paralelo_serial_tx with a symbol-level reference model.
module tb_paralelo_serial_tx;

  localparam int unsigned SC = 4;
  localparam logic [7:0]  BC = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       byte_start;
  logic       tx_active;

  paralelo_serial_tx #(.SYNC_COUNT(SC), .IDLE_SYM(BC)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .byte_start (byte_start),
    .tx_active  (tx_active)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges since reset, symbols loaded, buffer, current symbol
  int         t     = 0;
  int         loads = 0;
  logic       mhv   = 1'b0;
  logic [7:0] mhold = 8'd0;
  logic [7:0] cur   = 8'd0;
  logic       m_acc = 1'b0;

  // Loopback receiver: reassembles bytes framed by byte_start, drops commas
  logic [7:0] rx_q[$];
  int         cbits = 0;
  logic [7:0] cval  = 8'd0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // One clock: advance the model over the edge, then compare all outputs
  task automatic step();
    logic pre_active;
    logic pre_ready;
    logic e_do;
    logic e_bs;
    int   k;
    pre_active = (loads >= SC);
    pre_ready  = pre_active && !mhv;
    m_acc      = 1'b0;
    if (reset) begin
      t = 0; loads = 0; mhv = 1'b0; mhold = 8'd0; cur = 8'd0;
      e_do = 1'b0; e_bs = 1'b0;
    end else begin
      k = t % 8;
      if (k == 0) begin
        cur = BC;
        if (pre_active && mhv) begin
          cur = mhold;
          mhv = 1'b0;
        end
        loads++;
      end
      if (valid_in && pre_ready) begin
        mhv   = 1'b1;
        mhold = data_in;
        m_acc = 1'b1;
      end
      e_do = cur[7 - k];
      e_bs = (k == 0);
      t++;
    end
    @(posedge clk_32f);
    #1;
    chk("data_out",   {7'd0, data_out},   {7'd0, e_do});
    chk("byte_start", {7'd0, byte_start}, {7'd0, e_bs});
    chk("ready_out",  {7'd0, ready_out},  {7'd0, (loads >= SC) && !mhv});
    chk("tx_active",  {7'd0, tx_active},  {7'd0, (loads >= SC)});
    if (!reset) begin
      if (byte_start) begin
        cbits = 1;
        cval  = {7'd0, data_out};
      end else if (cbits > 0) begin
        cval  = {cval[6:0], data_out};
        cbits++;
      end
      if (cbits == 8) begin
        if (cval != BC) rx_q.push_back(cval);
        cbits = 0;
      end
    end else begin
      cbits = 0;
    end
  endtask

  // Present a byte and hold it until accepted (bounded); valid stays high
  task automatic send_byte(input logic [7:0] b);
    logic done;
    done     = 1'b0;
    data_in  = b;
    valid_in = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      step();
      done = m_acc;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $error("FAIL accept_timeout observed=0 expected=1 byte=%0h", b);
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Sync: four commas, ready/tx_active rise on the fourth load
    idle(32);
    chk("sync_loads", 8'(loads), 8'(SC));

    // Single byte then idle fill
    rx_q.delete();
    send_byte(8'hA5);
    idle(20);
    chk("a5_count", 8'(rx_q.size()), 8'd1);
    if (rx_q.size() > 0) chk("a5_data", rx_q[0], 8'hA5);

    // Back-to-back stream, no idle gaps
    idle($urandom_range(0, 9));
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h00);
    idle(24);

    // Accept landing exactly on a load edge with an empty buffer
    for (int i = 0; i < 16 && ((t % 8) != 0 || mhv); i++) step();
    chk("align_load", 8'(t % 8), 8'd0);
    data_in  = 8'h3C;
    valid_in = 1'b1;
    step();
    chk("3c_accept_on_load", {7'd0, m_acc}, 8'd1);
    idle(20);

    // Reset mid-symbol with a byte waiting in the buffer
    send_byte(8'h5A);
    send_byte(8'h77);
    valid_in = 1'b0;
    for (int i = 0; i < 16 && (t % 8) != 4; i++) step();
    chk("mid_byte_hold", {7'd0, mhv}, 8'd1);
    rx_q.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(40);
    chk("reset_drop_count", 8'(rx_q.size()), 8'd0);

    // Loopback reception of three bytes after lock
    rx_q.delete();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(24);
    chk("loop_count", 8'(rx_q.size()), 8'd3);
    if (rx_q.size() == 3) begin
      chk("loop_0", rx_q[0], 8'h11);
      chk("loop_1", rx_q[1], 8'h22);
      chk("loop_2", rx_q[2], 8'h33);
    end

    // Randomized bytes with random idle gaps, checked bit by bit by the model
    for (int n = 0; n < 16; n++) begin
      send_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 11));
    end
    idle(24);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
